sigdel_channel_scheduler: RTL and testbench

Time-multiplexed first-order sigma-delta engine. It shares one integrator/comparator datapath among NUM_CHANNELS channels, one channel per system clock cycle (200 MHz system clock, 10 channels, 20 MHz per-channel modulator rate). It owns the per-channel sample registers and accumulator contexts, sequences the round-robin slot counter, and emits one bitstream bit per channel per frame. It sits between the sample-producing front end and the per-channel bitstream consumers (decimators / output pins).

---
 rtl/sigdel_channel_scheduler.sv | 135 +++++++++++++
 tb/tb_sigdel_channel_scheduler.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sigdel_channel_scheduler.sv
// Time-multiplexed first-order sigma-delta modulator: one shared integrator and
// comparator serve NUM_CHANNELS channels in round-robin, one channel per clock.
`timescale 1ns/1ps

module sigdel_channel_scheduler #(
  parameter int NUM_CHANNELS         = 10,
  parameter int CH_IDX_W             = 4,
  parameter int INPUT_BITWIDTH       = 24,
  parameter int ACCUMULATOR_BITWIDTH = 28
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      clear_all,
  input  logic                      wr_en,
  input  logic [CH_IDX_W-1:0]       wr_channel,
  input  logic [INPUT_BITWIDTH-1:0] wr_data,
  output logic                      bit_out,
  output logic [CH_IDX_W-1:0]       bit_channel,
  output logic                      bit_valid,
  output logic [NUM_CHANNELS-1:0]   bits_parallel,
  output logic                      frame_strobe,
  output logic                      wr_error
);

  localparam int IW = INPUT_BITWIDTH;
  localparam int AW = ACCUMULATOR_BITWIDTH;

  // Feedback levels are the input full-scale values sign-extended into the integrator.
  localparam logic [AW-1:0] FULL_POS = {{(AW-IW+1){1'b0}}, {(IW-1){1'b1}}};
  localparam logic [AW-1:0] FULL_NEG = {{(AW-IW+1){1'b1}}, {(IW-1){1'b0}}};

  localparam logic [CH_IDX_W-1:0] LAST_SLOT = CH_IDX_W'(NUM_CHANNELS - 1);
  localparam logic [CH_IDX_W:0]   NUM_CH_W  = (CH_IDX_W + 1)'(NUM_CHANNELS);

  logic [CH_IDX_W-1:0]     slot_q;
  logic [CH_IDX_W-1:0]     slot_d;
  logic [IW-1:0]           sample_q [NUM_CHANNELS];
  logic [AW-1:0]           acc_q    [NUM_CHANNELS];
  logic [AW-1:0]           acc_d;
  logic                    bitOut_q;
  logic [CH_IDX_W-1:0]     bitChannel_q;
  logic                    bitValid_q;
  logic [NUM_CHANNELS-1:0] bitsParallel_q;
  logic                    frameStrobe_q;
  logic                    wrError_q;

  logic [AW-1:0] accCur;
  logic [IW-1:0] sampleCur;
  logic [AW-1:0] sampleExt;
  logic [AW-1:0] feedback;
  logic          comp;
  logic          lastSlot;
  logic          wrInRange;

  // Shared datapath: select the active channel's context and compute its next integrator value.
  always_comb begin
    accCur    = '0;
    sampleCur = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (slot_q == CH_IDX_W'(c)) begin
        accCur    = acc_q[c];
        sampleCur = sample_q[c];
      end
    end
    comp      = ~accCur[AW-1];
    feedback  = comp ? FULL_POS : FULL_NEG;
    sampleExt = {{(AW-IW){sampleCur[IW-1]}}, sampleCur};
    acc_d     = accCur + sampleExt - feedback;
    lastSlot  = (slot_q == LAST_SLOT);
    slot_d    = lastSlot ? '0 : slot_q + CH_IDX_W'(1);
    wrInRange = ({1'b0, wr_channel} < NUM_CH_W);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slot_q         <= '0;
      bitOut_q       <= 1'b0;
      bitChannel_q   <= '0;
      bitValid_q     <= 1'b0;
      bitsParallel_q <= '0;
      frameStrobe_q  <= 1'b0;
      wrError_q      <= 1'b0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        acc_q[c]    <= '0;
        sample_q[c] <= '0;
      end
    end else begin
      if (clear_all) begin
        slot_q        <= '0;
        bitValid_q    <= 1'b0;
        frameStrobe_q <= 1'b0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
          acc_q[c] <= '0;
        end
      end else if (enable) begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
          if (slot_q == CH_IDX_W'(c)) begin
            acc_q[c]          <= acc_d;
            bitsParallel_q[c] <= comp;
          end
        end
        bitOut_q      <= comp;
        bitChannel_q  <= slot_q;
        bitValid_q    <= 1'b1;
        frameStrobe_q <= lastSlot;
        slot_q        <= slot_d;
      end else begin
        bitValid_q    <= 1'b0;
        frameStrobe_q <= 1'b0;
      end

      // The step above reads the old sample, so a same-cycle write lands on the next visit.
      if (wr_en) begin
        if (wrInRange) begin
          for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (wr_channel == CH_IDX_W'(c)) begin
              sample_q[c] <= wr_data;
            end
          end
        end else begin
          wrError_q <= 1'b1;
        end
      end
    end
  end

  assign bit_out       = bitOut_q;
  assign bit_channel   = bitChannel_q;
  assign bit_valid     = bitValid_q;
  assign bits_parallel = bitsParallel_q;
  assign frame_strobe  = frameStrobe_q;
  assign wr_error      = wrError_q;

endmodule

// File: tb/tb_sigdel_channel_scheduler.sv
// Scoreboard bench for sigdel_channel_scheduler: stimulus pushes expected bits,
// a negedge monitor pops them whenever the DUT raises bit_valid.
`timescale 1ns/1ps

module tb_sigdel_channel_scheduler;

  localparam int NUM_CH   = 10;
  localparam longint FULL_POS = 64'sd8388607;
  localparam longint FULL_NEG = -64'sd8388608;

  typedef struct {
    logic       bitv;
    logic [3:0] ch;
    logic       fs;
    logic [9:0] bp;
    logic       werr;
  } expItem_t;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        clear_all;
  logic        wr_en;
  logic [3:0]  wr_channel;
  logic [23:0] wr_data;
  logic        bit_out;
  logic [3:0]  bit_channel;
  logic        bit_valid;
  logic [9:0]  bits_parallel;
  logic        frame_strobe;
  logic        wr_error;

  expItem_t expQ[$];
  longint   mAcc[NUM_CH];
  longint   mSample[NUM_CH];
  int       mS;
  logic [9:0] mBp;
  logic     mWerr;
  int       errorCount;
  int       checkCount;

  sigdel_channel_scheduler #(
    .NUM_CHANNELS(10),
    .CH_IDX_W(4),
    .INPUT_BITWIDTH(24),
    .ACCUMULATOR_BITWIDTH(28)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .clear_all(clear_all),
    .wr_en(wr_en),
    .wr_channel(wr_channel),
    .wr_data(wr_data),
    .bit_out(bit_out),
    .bit_channel(bit_channel),
    .bit_valid(bit_valid),
    .bits_parallel(bits_parallel),
    .frame_strobe(frame_strobe),
    .wr_error(wr_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reduce an integer into the signed 28-bit two's-complement range.
  function automatic longint wrapAcc(input longint x);
    longint m;
    m = x & ((64'sd1 <<< 28) - 1);
    if (m >= (64'sd1 <<< 27)) m = m - (64'sd1 <<< 28);
    return m;
  endfunction

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checkCount++;
    if (act != exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, then advance the reference model across the same edge.
  task automatic applyStimulus(input logic en, input logic clr, input logic we,
                               input logic [3:0] wch, input logic [23:0] wd);
    expItem_t e;
    longint   fb;
    logic     comp;
    logic     push;
    enable     = en;
    clear_all  = clr;
    wr_en      = we;
    wr_channel = wch;
    wr_data    = wd;
    @(posedge clock);
    push = 1'b0;
    e    = '{default: '0};
    if (clr) begin
      for (int i = 0; i < NUM_CH; i++) mAcc[i] = 0;
      mS = 0;
    end else if (en) begin
      comp     = (mAcc[mS] >= 0);
      fb       = comp ? FULL_POS : FULL_NEG;
      mAcc[mS] = wrapAcc(mAcc[mS] + mSample[mS] - fb);
      mBp[mS]  = comp;
      e.bitv   = comp;
      e.ch     = 4'(mS);
      e.fs     = (mS == NUM_CH - 1);
      push     = 1'b1;
      mS       = (mS == NUM_CH - 1) ? 0 : mS + 1;
    end
    if (we) begin
      if (int'(wch) < NUM_CH) mSample[wch] = longint'($signed(wd));
      else mWerr = 1'b1;
    end
    if (push) begin
      e.bp   = mBp;
      e.werr = mWerr;
      expQ.push_back(e);
    end
    #2;
  endtask

  task automatic resetModel();
    for (int i = 0; i < NUM_CH; i++) begin
      mAcc[i]    = 0;
      mSample[i] = 0;
    end
    mS    = 0;
    mBp   = '0;
    mWerr = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_bit_out"}, bit_out, 0);
    checkOutput({tag, "_bit_channel"}, bit_channel, 0);
    checkOutput({tag, "_bit_valid"}, bit_valid, 0);
    checkOutput({tag, "_bits_parallel"}, bits_parallel, 0);
    checkOutput({tag, "_frame_strobe"}, frame_strobe, 0);
    checkOutput({tag, "_wr_error"}, wr_error, 0);
  endtask

  // Monitor: compare every presented bit against the oldest expectation.
  initial begin
    expItem_t e;
    forever begin
      @(negedge clock);
      if (reset) begin
        if (bit_valid) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected_valid", bit_valid, 0);
          end else begin
            e = expQ.pop_front();
            checkOutput("bit_out", bit_out, e.bitv);
            checkOutput("bit_channel", bit_channel, e.ch);
            checkOutput("frame_strobe", frame_strobe, e.fs);
            checkOutput("bits_parallel", bits_parallel, e.bp);
            checkOutput("wr_error", wr_error, e.werr);
          end
        end else begin
          checkOutput("strobe_idle", frame_strobe, 0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    errorCount = 0;
    checkCount = 0;
    resetModel();
    reset      = 1'b0;
    enable     = 1'b0;
    clear_all  = 1'b0;
    wr_en      = 1'b0;
    wr_channel = '0;
    wr_data    = '0;
    repeat (3) @(posedge clock);
    #2;
    checkResetOutputs("por");
    reset = 1'b1;

    // All-zero samples: every channel toggles 1,0,1,0 starting from a full frame of ones.
    repeat (10) applyStimulus(1, 0, 0, 0, 0);
    checkOutput("frame1_all_ones", bits_parallel, 10'h3FF);
    repeat (10) applyStimulus(1, 0, 0, 0, 0);
    checkOutput("frame2_all_zeros", bits_parallel, 10'h000);
    repeat (5) applyStimulus(1, 0, 0, 0, 0);

    // Full-scale samples on channels 2 and 5.
    applyStimulus(1, 0, 1, 4'd2, 24'h7FFFFF);
    applyStimulus(1, 0, 1, 4'd5, 24'h800000);
    repeat (30) applyStimulus(1, 0, 0, 0, 0);
    checkOutput("ch2_const_one", bits_parallel[2], 1);
    checkOutput("ch5_const_zero", bits_parallel[5], 0);

    // Write channel 3 exactly while slot 3 is being processed.
    while (mS != 3) applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 4'd3, 24'h800000);
    repeat (22) applyStimulus(1, 0, 0, 0, 0);
    checkOutput("ch3_new_sample", bits_parallel[3], 0);

    // Out-of-range write is dropped and latches the error flag.
    applyStimulus(1, 0, 1, 4'd12, 24'd100);
    checkOutput("wr_error_set", wr_error, 1);
    repeat (10) applyStimulus(1, 0, 0, 0, 0);

    // Freeze mid-frame at slot 4, then resume.
    while (mS != 4) applyStimulus(1, 0, 0, 0, 0);
    repeat (7) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("pause_valid_low", bit_valid, 0);
    repeat (12) applyStimulus(1, 0, 0, 0, 0);

    // clear_all wins over enable; sequencing restarts at slot 0 from zero accumulators.
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("clear_valid_low", bit_valid, 0);
    repeat (12) applyStimulus(1, 0, 0, 0, 0);
    checkOutput("wr_error_sticky", wr_error, 1);

    // Asynchronous reset mid-frame with samples loaded.
    while (mS != 6) applyStimulus(1, 0, 0, 0, 0);
    #5;
    checkOutput("queue_before_reset", expQ.size(), 0);
    expQ.delete();
    reset = 1'b0;
    #1;
    checkResetOutputs("async");
    resetModel();
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b1;
    repeat (10) applyStimulus(1, 0, 0, 0, 0);
    checkOutput("post_reset_all_ones", bits_parallel, 10'h3FF);
    repeat (10) applyStimulus(1, 0, 0, 0, 0);
    checkOutput("post_reset_all_zeros", bits_parallel, 10'h000);

    repeat (3) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("queue_drained", expQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
